// File: rtl/tone_buzzer_gen.sv
// -----------------------------------------------------------------------------
// tone_buzzer_gen
//   Multi-tone square-wave buzzer driver. A half-period divider table turns the
//   system clock into NUM_TONES selectable tones. A tone plays either for a
//   programmed number of 1 ms ticks (one-shot) or until stopped (continuous).
//   The tone can be retuned while playing; a retune only lands on a toggle
//   boundary, so no half-cycle is ever cut short.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   1-cycle request; latches tone_sel, duration, continuous
//   stop       in   ends playback (wins over start in the same cycle)
//   continuous in   1 = ignore duration, play until stop
//   tone_sel   in   tone index; sampled at start and at every toggle
//   duration   in   play length in ms ticks
//   buzzer     out  square-wave output (registered)
//   busy       out  high while playing (registered)
//   done       out  1-cycle pulse when playback ends (registered)
// -----------------------------------------------------------------------------
module tone_buzzer_gen #(
  parameter int                           CLK_HZ     = 50_000_000,
  parameter int                           NUM_TONES  = 4,
  parameter int                           SEL_W      = 2,
  parameter int                           DIV_W      = 20,
  parameter logic [NUM_TONES*DIV_W-1:0]   HALF_TABLE = {20'd47801, 20'd60241, 20'd75988, 20'd95785},
  parameter int                           DUR_W      = 16,
  parameter int                           TICK_DIV   = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  input  logic [SEL_W-1:0] tone_sel,
  input  logic [DUR_W-1:0] duration,
  output logic             buzzer,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W  = (NUM_TONES > 1) ? $clog2(NUM_TONES) : 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  // Elaboration-time sanity check of the parameter set.
  if ((2 ** SEL_W) < NUM_TONES || CLK_HZ <= 0) begin : g_param_check
    $error("tone_buzzer_gen: SEL_W too narrow for NUM_TONES or CLK_HZ not positive");
  end

  typedef enum logic {S_IDLE = 1'b0, S_PLAY = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [DIV_W-1:0]  half_cur_reg, half_cur_next;
  logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
  logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
  logic [DUR_W-1:0]  rem_reg, rem_next;
  logic              cont_reg, cont_next;
  logic              buzzer_reg, buzzer_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  // Unpacked half-period table; a zero entry would never toggle, so it is
  // promoted to 1.
  logic [DIV_W-1:0] half_tab [NUM_TONES];
  for (genvar gi = 0; gi < NUM_TONES; gi++) begin : g_tab
    localparam logic [DIV_W-1:0] ENTRY = HALF_TABLE[gi*DIV_W +: DIV_W];
    assign half_tab[gi] = (ENTRY == '0) ? DIV_W'(1) : ENTRY;
  end

  // Out-of-range selections clamp to the last table entry.
  logic [IDX_W-1:0] sel_idx;
  always_comb begin
    sel_idx = IDX_W'(NUM_TONES - 1);
    if (32'(tone_sel) < NUM_TONES) sel_idx = IDX_W'(tone_sel);
  end

  logic [DIV_W-1:0] half_lookup;
  assign half_lookup = half_tab[sel_idx];

  // Request decode shared by both states.
  logic go, zero_req, launch;
  assign go       = start & ~stop;
  assign zero_req = go & ~continuous & (duration == '0);
  assign launch   = go & ~zero_req;

  logic div_wrap, tick_wrap, natural_end, play_finish;
  assign div_wrap    = (div_cnt_reg == half_cur_reg - DIV_W'(1));
  assign tick_wrap   = (tick_cnt_reg == TICK_LAST);
  assign natural_end = ~cont_reg & tick_wrap & (rem_reg == DUR_W'(1));
  // A fresh start overrides a one-shot that happens to expire the same cycle;
  // a zero-length retrigger ends playback just as it would from idle.
  assign play_finish = stop | zero_req | (~go & natural_end);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      half_cur_reg <= '0;
      div_cnt_reg  <= '0;
      tick_cnt_reg <= '0;
      rem_reg      <= '0;
      cont_reg     <= 1'b0;
      buzzer_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      half_cur_reg <= half_cur_next;
      div_cnt_reg  <= div_cnt_next;
      tick_cnt_reg <= tick_cnt_next;
      rem_reg      <= rem_next;
      cont_reg     <= cont_next;
      buzzer_reg   <= buzzer_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (launch) state_next = S_PLAY;
      S_PLAY:  if (play_finish) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the playback datapath.
  always_comb begin
    half_cur_next = half_cur_reg;
    div_cnt_next  = div_cnt_reg;
    tick_cnt_next = tick_cnt_reg;
    rem_next      = rem_reg;
    cont_next     = cont_reg;
    buzzer_next   = buzzer_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (launch) begin
          half_cur_next = half_lookup;
          rem_next      = duration;
          cont_next     = continuous;
          div_cnt_next  = '0;
          tick_cnt_next = '0;
          buzzer_next   = 1'b0;
          busy_next     = 1'b1;
        end else if (zero_req) begin
          done_next = 1'b1;
        end
      end
      S_PLAY: begin
        if (play_finish) begin
          div_cnt_next  = '0;
          tick_cnt_next = '0;
          rem_next      = '0;
          buzzer_next   = 1'b0;
          busy_next     = 1'b0;
          done_next     = 1'b1;
        end else if (launch) begin
          half_cur_next = half_lookup;
          rem_next      = duration;
          cont_next     = continuous;
          div_cnt_next  = '0;
          tick_cnt_next = '0;
          buzzer_next   = 1'b0;
          busy_next     = 1'b1;
        end else begin
          // Reloading the half-period only at a toggle keeps every
          // half-cycle whole when tone_sel changes mid-play.
          if (div_wrap) begin
            buzzer_next   = ~buzzer_reg;
            div_cnt_next  = '0;
            half_cur_next = half_lookup;
          end else begin
            div_cnt_next = div_cnt_reg + DIV_W'(1);
          end
          if (tick_wrap) begin
            tick_cnt_next = '0;
            if (!cont_reg) rem_next = rem_reg - DUR_W'(1);
          end else begin
            tick_cnt_next = tick_cnt_reg + TICK_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign buzzer = buzzer_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_tone_buzzer_gen.sv
// -----------------------------------------------------------------------------
// tb_tone_buzzer_gen
//   Scenario tasks push the expected {buzzer, busy, done} for each cycle into a
//   scoreboard queue, drive the stimulus, then pop and compare one entry per
//   cycle. Expected waveforms come from the tone half-periods and the tick
//   arithmetic, not from the design.
// -----------------------------------------------------------------------------
module tb_tone_buzzer_gen;

  localparam int TICK  = 10;
  localparam int DUR_W = 4;
  localparam int SEL_W = 3;

  typedef struct {
    logic bz;
    logic bs;
    logic dn;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             continuous = 1'b0;
  logic [SEL_W-1:0] tone_sel = '0;
  logic [DUR_W-1:0] duration = '0;
  logic             buzzer, busy, done;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  tone_buzzer_gen #(
    .NUM_TONES  (4),
    .SEL_W      (SEL_W),
    .DIV_W      (20),
    .HALF_TABLE ({20'd8, 20'd6, 20'd4, 20'd3}),
    .DUR_W      (DUR_W),
    .TICK_DIV   (TICK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .tone_sel   (tone_sel),
    .duration   (duration),
    .buzzer     (buzzer),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic bz, input logic bs, input logic dn);
    exp_t e;
    e.bz = bz; e.bs = bs; e.dn = dn;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk(1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      if (i == 1) begin #3; rst_n = 1'b1; #1; end
      e = sb.pop_front();
      n_run++;
      if ({buzzer, busy, done} !== {e.bz, e.bs, e.dn}) begin
        n_fail++;
        $display("FAIL reset i=%0d buzzer/busy/done got %b%b%b want %b%b%b",
                 i, buzzer, busy, done, e.bz, e.bs, e.dn);
      end
      $display("[TB] reset i=%0d out=%b%b%b", i, buzzer, busy, done);
    end
  endtask

  // tone0 (half 3), 2 ms one-shot: ends exactly 2*TICK edges after start.
  task automatic test_one_shot();
    exp_t e;
    int len;
    len = 2 * TICK;
    sb.delete();
    for (int t = 0; t <= len + 1; t++) begin
      if (t < len)       sb.push_back(mk(((t / 3) % 2) == 1, 1'b1, 1'b0));
      else if (t == len) sb.push_back(mk(1'b0, 1'b0, 1'b1));
      else               sb.push_back(mk(1'b0, 1'b0, 1'b0));
    end
    tone_sel = 3'd0; duration = 4'd2; continuous = 1'b0; start = 1'b1;
    for (int t = 0; t <= len + 1; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      e = sb.pop_front();
      n_run++;
      if ({buzzer, busy, done} !== {e.bz, e.bs, e.dn}) begin
        n_fail++;
        $display("FAIL one_shot t=%0d buzzer/busy/done got %b%b%b want %b%b%b",
                 t, buzzer, busy, done, e.bz, e.bs, e.dn);
      end
      $display("[TB] one_shot t=%0d out=%b%b%b", t, buzzer, busy, done);
    end
  endtask

  // tone1 (half 4) continuous; switch to tone3 two cycles after the first
  // toggle. Toggles expected at 4, 8 (still 4 long), then every 8.
  task automatic test_retune();
    exp_t e;
    int   tog [4] = '{4, 8, 16, 24};
    int   n;
    sb.delete();
    for (int t = 0; t <= 32; t++) begin
      n = 0;
      for (int k = 0; k < 4; k++) if (tog[k] <= t) n++;
      if (t <= 30)      sb.push_back(mk((n % 2) == 1, 1'b1, 1'b0));
      else if (t == 31) sb.push_back(mk(1'b0, 1'b0, 1'b1));
      else              sb.push_back(mk(1'b0, 1'b0, 1'b0));
    end
    tone_sel = 3'd1; duration = 4'd0; continuous = 1'b1; start = 1'b1;
    for (int t = 0; t <= 32; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      e = sb.pop_front();
      n_run++;
      if ({buzzer, busy, done} !== {e.bz, e.bs, e.dn}) begin
        n_fail++;
        $display("FAIL retune t=%0d buzzer/busy/done got %b%b%b want %b%b%b",
                 t, buzzer, busy, done, e.bz, e.bs, e.dn);
      end
      $display("[TB] retune t=%0d out=%b%b%b", t, buzzer, busy, done);
      if (t == 6)  tone_sel = 3'd3;
      if (t == 30) stop = 1'b1;
      if (t == 31) stop = 1'b0;
    end
  endtask

  task automatic test_stop_retrigger();
    exp_t e;
    sb.delete();
    // A: tone2 (half 6) continuous, stop while buzzer high.
    for (int t = 0; t <= 7; t++) sb.push_back(mk(((t / 6) % 2) == 1, 1'b1, 1'b0));
    sb.push_back(mk(1'b0, 1'b0, 1'b1));
    sb.push_back(mk(1'b0, 1'b0, 1'b0));
    // B: start with stop in the same cycle -> nothing happens.
    for (int t = 0; t < 3; t++) sb.push_back(mk(1'b0, 1'b0, 1'b0));
    // C: tone2 playing, retrigger with tone0 at t=8, stop at t=15.
    for (int t = 0; t <= 7; t++) sb.push_back(mk(((t / 6) % 2) == 1, 1'b1, 1'b0));
    for (int t = 8; t <= 14; t++) sb.push_back(mk((((t - 8) / 3) % 2) == 1, 1'b1, 1'b0));
    sb.push_back(mk(1'b0, 1'b0, 1'b1));
    sb.push_back(mk(1'b0, 1'b0, 1'b0));

    tone_sel = 3'd2; duration = 4'd0; continuous = 1'b1; start = 1'b1;
    for (int t = 0; t <= 9; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      e = sb.pop_front();
      n_run++;
      if ({buzzer, busy, done} !== {e.bz, e.bs, e.dn}) begin
        n_fail++;
        $display("FAIL stop t=%0d buzzer/busy/done got %b%b%b want %b%b%b",
                 t, buzzer, busy, done, e.bz, e.bs, e.dn);
      end
      $display("[TB] stop t=%0d out=%b%b%b", t, buzzer, busy, done);
      if (t == 7) stop = 1'b1;
      if (t == 8) stop = 1'b0;
    end

    tone_sel = 3'd0; duration = 4'd3; continuous = 1'b0; start = 1'b1; stop = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      e = sb.pop_front();
      n_run++;
      if ({buzzer, busy, done} !== {e.bz, e.bs, e.dn}) begin
        n_fail++;
        $display("FAIL start_stop t=%0d buzzer/busy/done got %b%b%b want %b%b%b",
                 t, buzzer, busy, done, e.bz, e.bs, e.dn);
      end
      $display("[TB] start_stop t=%0d out=%b%b%b", t, buzzer, busy, done);
    end

    tone_sel = 3'd2; duration = 4'd0; continuous = 1'b1; start = 1'b1;
    for (int t = 0; t <= 16; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      e = sb.pop_front();
      n_run++;
      if ({buzzer, busy, done} !== {e.bz, e.bs, e.dn}) begin
        n_fail++;
        $display("FAIL retrigger t=%0d buzzer/busy/done got %b%b%b want %b%b%b",
                 t, buzzer, busy, done, e.bz, e.bs, e.dn);
      end
      $display("[TB] retrigger t=%0d out=%b%b%b", t, buzzer, busy, done);
      if (t == 7)  begin start = 1'b1; tone_sel = 3'd0; end
      if (t == 14) stop = 1'b1;
      if (t == 15) stop = 1'b0;
    end
  endtask

  task automatic test_zero_clamp();
    exp_t e;
    sb.delete();
    sb.push_back(mk(1'b0, 1'b0, 1'b1));
    sb.push_back(mk(1'b0, 1'b0, 1'b0));
    sb.push_back(mk(1'b0, 1'b0, 1'b0));
    for (int t = 0; t <= 19; t++) sb.push_back(mk(((t / 8) % 2) == 1, 1'b1, 1'b0));
    sb.push_back(mk(1'b0, 1'b0, 1'b1));

    tone_sel = 3'd0; duration = 4'd0; continuous = 1'b0; start = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      e = sb.pop_front();
      n_run++;
      if ({buzzer, busy, done} !== {e.bz, e.bs, e.dn}) begin
        n_fail++;
        $display("FAIL zero_dur t=%0d buzzer/busy/done got %b%b%b want %b%b%b",
                 t, buzzer, busy, done, e.bz, e.bs, e.dn);
      end
      $display("[TB] zero_dur t=%0d out=%b%b%b", t, buzzer, busy, done);
    end

    // Index 5 is beyond the table and must play the last tone (half 8).
    tone_sel = 3'd5; duration = 4'd0; continuous = 1'b1; start = 1'b1;
    for (int t = 0; t <= 20; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      e = sb.pop_front();
      n_run++;
      if ({buzzer, busy, done} !== {e.bz, e.bs, e.dn}) begin
        n_fail++;
        $display("FAIL clamp t=%0d buzzer/busy/done got %b%b%b want %b%b%b",
                 t, buzzer, busy, done, e.bz, e.bs, e.dn);
      end
      $display("[TB] clamp t=%0d out=%b%b%b", t, buzzer, busy, done);
      if (t == 19) stop = 1'b1;
      if (t == 20) stop = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    sb.delete();
    for (int t = 0; t <= 7; t++) sb.push_back(mk(((t / 6) % 2) == 1, 1'b1, 1'b0));
    tone_sel = 3'd2; duration = 4'd0; continuous = 1'b1; start = 1'b1;
    for (int t = 0; t <= 7; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      e = sb.pop_front();
      n_run++;
      if ({buzzer, busy, done} !== {e.bz, e.bs, e.dn}) begin
        n_fail++;
        $display("FAIL pre_reset t=%0d buzzer/busy/done got %b%b%b want %b%b%b",
                 t, buzzer, busy, done, e.bz, e.bs, e.dn);
      end
      $display("[TB] pre_reset t=%0d out=%b%b%b", t, buzzer, busy, done);
    end
    // Reset lands between edges while buzzer is high.
    sb.push_back(mk(1'b0, 1'b0, 1'b0));
    #3 rst_n = 1'b0;
    #1;
    e = sb.pop_front();
    n_run++;
    if ({buzzer, busy, done} !== {e.bz, e.bs, e.dn}) begin
      n_fail++;
      $display("FAIL async_reset_now buzzer/busy/done got %b%b%b want %b%b%b",
               buzzer, busy, done, e.bz, e.bs, e.dn);
    end
    $display("[TB] async_reset_now out=%b%b%b", buzzer, busy, done);
    for (int t = 0; t < 4; t++) begin
      sb.push_back(mk(1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      if (t == 0) begin #2; rst_n = 1'b1; end
      e = sb.pop_front();
      n_run++;
      if ({buzzer, busy, done} !== {e.bz, e.bs, e.dn}) begin
        n_fail++;
        $display("FAIL post_reset t=%0d buzzer/busy/done got %b%b%b want %b%b%b",
                 t, buzzer, busy, done, e.bz, e.bs, e.dn);
      end
      $display("[TB] post_reset t=%0d out=%b%b%b", t, buzzer, busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_retune();
    test_stop_retrigger();
    test_zero_clamp();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tone_buzzer_gen.md
Name: tone_buzzer_gen

Overview:
- Parametrised multi-tone buzzer driver with one clock domain.
- Derives N selectable square-wave tones from the system clock using a half-period divider table, so no per-tone clock inputs are needed.
- Plays a tone for a programmed number of milliseconds (one-shot) or until stopped (continuous).
- Retunes glitch-free while playing. Sits between the game/state FSM and the board buzzer pin.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency; documentation only, no logic depends on it.
- NUM_TONES, 4, number of table entries.
- SEL_W, 2, tone_sel width; must satisfy 2**SEL_W >= NUM_TONES.
- DIV_W, 20, width of each half-period entry and of the divider counter.
- HALF_TABLE, {20'd47801,20'd60241,20'd75988,20'd95785}, packed NUM_TONES*DIV_W half-periods in clk cycles. Entry 0 is in the LSBs. Defaults give 261/329/415/523 Hz for tones 0..3.
- DUR_W, 16, duration width in ms.
- TICK_DIV, 50000, clk cycles per 1 ms tick.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle request; latches tone_sel, duration, continuous.
- stop  in  1  ends playback.
- continuous  in  1  1 = ignore duration, play until stop.
- tone_sel  in  SEL_W  tone index, sampled at start and continuously while playing.
- duration  in  DUR_W  play length in ms ticks.
- buzzer  out  1  square-wave output.
- busy  out  1  high while in PLAY.
- done  out  1  1-cycle pulse when playback ends.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; buzzer=0, busy=0, done=0; all counters 0. Takes effect immediately, including mid-play.
- FSM has two states: IDLE and PLAY. All outputs are registered.
- Table lookup: an index >= NUM_TONES clamps to NUM_TONES-1. A table entry of 0 is treated as 1.

IDLE:
- start=1 and stop=0, with continuous=1 or duration!=0: go to PLAY.
  - Latch half_cur = table[tone_sel], rem = duration, cont = continuous.
  - div_cnt=0, tick_cnt=0, buzzer=0, busy=1.
- start=1 with duration=0 and continuous=0: stay IDLE; done=1 on the next cycle.
- start=1 and stop=1 together: stop wins; no action.

PLAY, each cycle:
- Divider: if div_cnt == half_cur-1, toggle buzzer, set div_cnt=0, and reload half_cur from the current tone_sel. Otherwise div_cnt+1.
- Consequences:
  - Retune takes effect only at a toggle boundary, so a half-cycle is never truncated.
  - First rising edge of buzzer is HALF clocks after the start edge.
- Tick: if tick_cnt == TICK_DIV-1, set tick_cnt=0 and decrement rem (when cont=0). Otherwise tick_cnt+1.
- End condition: stop=1, OR (cont=0 AND tick wrap AND rem==1).
  - On end: next edge sets state=IDLE, buzzer=0 (forced, even mid-high), busy=0, done=1 for exactly one cycle.
- Retrigger: start=1 and stop=0 in PLAY restarts playback exactly as from IDLE (relatch, counters 0, buzzer 0). No done pulse.
- start and stop in the same PLAY cycle: stop wins; playback ends.

Timing:
- One-shot play of D ms, started at edge k, ends at edge k + D*TICK_DIV.
- done is high during the cycle after that edge.

Test Plan:
- Bench overrides: HALF_TABLE={8,6,4,3} (tone0=3 … tone3=8), TICK_DIV=10, DUR_W=4.
- One-shot: start at edge k, tone0, duration=2 -> buzzer rises k+3, falls k+6, toggles every 3 cycles; at k+20 buzzer=0, busy=0, done=1 for one cycle.
- Retune: continuous=1, tone1 (half 4); change tone_sel to 3 two cycles after a toggle -> current half still lasts 4 cycles; subsequent halves last 8; no done.
- Stop/retrigger: continuous tone2 playing, stop while buzzer=1 -> next edge buzzer=0, done=1. Then start with stop=1 in the same cycle -> stays IDLE, no busy. Start tone0 mid-play -> buzzer=0 next edge, rises 3 cycles later, no done.
- Zero/clamp: duration=0, continuous=0 -> done at k+1, busy stays 0. Separately, a tone_sel beyond NUM_TONES-1 plays tone 3 (half 8).
- Async reset: drop rst_n mid-play between clock edges -> buzzer, busy, done go 0 immediately. After release, outputs stay 0 until the next start.
